dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit: the initiator side of the data-memory port. It accepts one load or store request at a time from the processor datapath and drives the data memory's word-wide port (`we`, `a`, `wd`, `rd`) with a combinational read and a write on the clock edge. It performs sub-word stores as a read-modify-write, aligns and extends sub-word loads, and rejects misaligned accesses.

## Interface
Parameters:
- `WIDTH`, default 32: data and address width. Only 32 is supported, because byte lanes are fixed at 4.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: a request is present.
- `req_ready`, out, 1: the unit can accept a request.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned`, in, 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr`, in, WIDTH: byte address.
- `req_wdata`, in, WIDTH: store data, right-justified.
- `resp_valid`, out, 1: single-cycle completion pulse.
- `resp_err`, out, 1: the request was rejected; qualified by `resp_valid`.
- `resp_rdata`, out, WIDTH: load result; 0 for stores and errors.
- `mem_we`, out, 1: memory write enable.
- `mem_a`, out, WIDTH: memory address, always word-aligned (`{addr_q[31:2],2'b00}`).
- `mem_wd`, out, WIDTH: memory write data.
- `mem_rd`, in, WIDTH: memory read data, combinational from `mem_a`.

## Operation
- **States:** IDLE, EXEC, WRITE, RESP. The reset state is IDLE.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture addr, size, we, unsigned and wdata into registers, then go to EXEC.
- **EXEC:** `mem_a` is driven from the captured address. Action by request type:
  - Error (see "Error conditions" below): no memory write; go to RESP with the error flag set.
  - Load: register the extracted and extended lane into `rdata_q`; go to RESP.
  - Word store: `mem_we`=1, `mem_wd`=wdata; go to RESP.
  - Byte or half store: register the merge word into `merge_q`, i.e. `mem_rd` with the target lane(s) replaced by the low bits of wdata; go to WRITE.
- **WRITE:** `mem_we`=1, `mem_wd`=`merge_q`; go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle; go to IDLE. There is no response backpressure.
- **Lanes (little-endian):**
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - Half h = `addr[1]` occupies bits [16h+15:16h].
- **Error conditions:**
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - `req_size`=11.
- `mem_we` is a decode of state and the captured registers only; it is never driven from `req_*` directly.
- `mem_wd`=0 whenever `mem_we`=0.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0.
- While `reset_n`=0, no request is captured.
- **Cycle numbering:** a request is accepted in cycle 0, i.e. `req_valid` and `req_ready` are both high at the cycle-0 rising edge.
- **Load, word store, error:** EXEC in cycle 1, `resp_valid` in cycle 2.
- **Word store write:** committed at the end of cycle 1.
- **Byte or half store:**
  - Memory read in cycle 1.
  - `mem_we` high in cycle 2 only.
  - `resp_valid` in cycle 3.
- **Throughput:** `req_ready`=0 from cycle 1 through the RESP cycle. The next request can be accepted in the cycle after RESP.
- **Load-after-store:** a load accepted after a store's response sees the stored data.
- **Reset mid-operation:**
  - The state returns to IDLE immediately and `mem_we` drops combinationally.
  - An interrupted read-modify-write leaves memory unchanged.
  - No response is produced for the aborted request.

## Configuration
- **`DMEM_LSU_SUBWORD_EN` defined:** byte and half accesses are supported as described above.
- **`DMEM_LSU_SUBWORD_EN` undefined:**
  - Only word accesses are supported. Any `req_size` other than 10 is an error (`resp_err`=1 in cycle 2, no memory write).
  - The WRITE state and `merge_q` are not built.

## Test plan
Memory word 0x4 is preloaded with 0x8899AABB.
- Byte load at 0x7, signed → `resp_valid` in cycle 2, `resp_rdata`=0xFFFFFF88. The same load unsigned → 0x00000088.
- Half store of 0x1234 to 0x6 → `mem_we` high only in cycle 2, `mem_wd`=0x1234AABB, `resp_valid` in cycle 3. A following word load of 0x4 → 0x1234AABB.
- Word store of 0xDEADBEEF to 0x10 (write at end of cycle 1, response in cycle 2), then word load of 0x10 → 0xDEADBEEF, `resp_err`=0.
- Half load at 0x5, and separately a word store at 0x6 → `resp_err`=1, `resp_rdata`=0, `mem_we` never high, memory unchanged.
- Byte store of 0x55 to 0x4, with `reset_n` pulsed low during the WRITE cycle → `mem_we` falls immediately, word 0x4 stays 0x8899AABB, no `resp_valid`. After release, `req_ready`=1 and a byte load at 0x4 returns 0xFFFFFFBB.
- With `DMEM_LSU_SUBWORD_EN` undefined: byte load at 0x4 → `resp_err`=1 in cycle 2; word load at 0x4 → 0x8899AABB.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory port with sub-word support.
// Define DMEM_LSU_SUBWORD_EN to build byte/half accesses; otherwise word only.
module dmem_lsu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
`ifdef DMEM_LSU_SUBWORD_EN
        WRITE = 2'd2,
`endif
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [1:0]       size_q;
    logic             we_q;
    logic             err_q;

    logic             err_c;
    logic             word_wr;
    logic [WIDTH-1:0] load_c;

`ifdef DMEM_LSU_SUBWORD_EN
    logic             uns_q;
    logic [WIDTH-1:0] merge_q;
    logic [WIDTH-1:0] merge_c;
    logic [WIDTH-1:0] lane_mask;
    logic [WIDTH-1:0] shifted;
    logic [4:0]       sh;
`else
    logic             unused_uns;
    assign unused_uns = req_unsigned;
`endif

    // Misalignment and illegal-size detection on the captured request.
    always_comb begin
        err_c = 1'b0;
`ifdef DMEM_LSU_SUBWORD_EN
        unique case (size_q)
            2'b00:   err_c = 1'b0;
            2'b01:   err_c = addr_q[0];
            2'b10:   err_c = |addr_q[1:0];
            default: err_c = 1'b1;
        endcase
`else
        err_c = (size_q != 2'b10) || (addr_q[1:0] != 2'b00);
`endif
    end

`ifdef DMEM_LSU_SUBWORD_EN
    assign sh      = {addr_q[1:0], 3'b000};
    assign shifted = mem_rd >> sh;

    always_comb begin
        load_c = mem_rd;
        unique case (size_q)
            2'b00: begin
                if (uns_q)
                    load_c = {{(WIDTH-8){1'b0}}, shifted[7:0]};
                else
                    load_c = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                if (uns_q)
                    load_c = {{(WIDTH-16){1'b0}}, shifted[15:0]};
                else
                    load_c = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: load_c = mem_rd;
        endcase
    end

    always_comb begin
        lane_mask = '0;
        if (size_q == 2'b00)
            lane_mask = WIDTH'(8'hFF) << sh;
        else
            lane_mask = WIDTH'(16'hFFFF) << sh;
        merge_c = (mem_rd & ~lane_mask) | ((wdata_q << sh) & lane_mask);
    end
`else
    assign load_c = mem_rd;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (req_valid)
                    next_state = EXEC;
            end
            EXEC: begin
`ifdef DMEM_LSU_SUBWORD_EN
                if (err_c || !we_q || size_q == 2'b10)
                    next_state = RESP;
                else
                    next_state = WRITE;
`else
                next_state = RESP;
`endif
            end
`ifdef DMEM_LSU_SUBWORD_EN
            WRITE: next_state = RESP;
`endif
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Write enable depends only on state and captured fields, so reset kills it at once.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = (state == RESP) ? rdata_q : '0;
        mem_a      = {addr_q[WIDTH-1:2], 2'b00};
        word_wr    = (state == EXEC) && we_q && !err_c && (size_q == 2'b10);
        mem_we     = word_wr;
        mem_wd     = word_wr ? wdata_q : '0;
`ifdef DMEM_LSU_SUBWORD_EN
        if (state == WRITE) begin
            mem_we = 1'b1;
            mem_wd = merge_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef DMEM_LSU_SUBWORD_EN
            uns_q   <= 1'b0;
            merge_q <= '0;
`endif
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                we_q    <= req_we;
                err_q   <= 1'b0;
                rdata_q <= '0;
`ifdef DMEM_LSU_SUBWORD_EN
                uns_q   <= req_unsigned;
`endif
            end
            if (state == EXEC) begin
                err_q <= err_c;
                if (!we_q && !err_c)
                    rdata_q <= load_c;
`ifdef DMEM_LSU_SUBWORD_EN
                merge_q <= merge_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small word memory model.
// Expected values follow the DMEM_LSU_SUBWORD_EN build setting.
module tb_dmem_lsu;

`ifdef DMEM_LSU_SUBWORD_EN
    localparam bit SUB     = 1'b1;
    localparam int RST_CYC = 2;
`else
    localparam bit SUB     = 1'b0;
    localparam int RST_CYC = 1;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:15];

    int checks = 0;
    int errors = 0;

    dmem_lsu #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_wd       (mem_wd),
        .mem_rd       (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_a[5:2]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] d, input int ecyc, input logic eerr,
                       input logic [31:0] erd, input logic [7:0] emask,
                       input logic [31:0] ewd);
        int          rcyc;
        int          npulse;
        logic        rerr;
        logic [31:0] rrd;
        logic [7:0]  wmask;
        logic [31:0] wdv;
        logic        rdy_low;
        logic        wd_zero;
        rcyc    = 0;
        npulse  = 0;
        rerr    = 1'b0;
        rrd     = '0;
        wmask   = '0;
        wdv     = '0;
        rdy_low = 1'b1;
        wd_zero = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_we) begin
                wmask[k] = 1'b1;
                wdv      = mem_wd;
            end else if (mem_wd !== 32'd0) begin
                wd_zero = 1'b0;
            end
            if (npulse == 0 && req_ready)
                rdy_low = 1'b0;
            if (resp_valid) begin
                if (npulse == 0) begin
                    rcyc = k;
                    rerr = resp_err;
                    rrd  = resp_rdata;
                end
                npulse++;
            end
        end
        chk({tag, "_resp_cycle"}, rcyc, ecyc);
        chk({tag, "_resp_pulses"}, npulse, 32'd1);
        chk({tag, "_err"}, {31'b0, rerr}, {31'b0, eerr});
        chk({tag, "_rdata"}, rrd, erd);
        chk({tag, "_we_cycles"}, {24'b0, wmask}, {24'b0, emask});
        chk({tag, "_wd"}, wdv, ewd);
        chk({tag, "_ready_low"}, {31'b0, rdy_low}, 32'd1);
        chk({tag, "_wd_idle_zero"}, {31'b0, wd_zero}, 32'd1);
    endtask

    initial begin
        int nresp;
        for (int i = 0; i < 16; i++)
            mem[i] = 32'h0;
        mem[1]       = 32'h8899AABB;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        reset_n = 1'b1;

        run("lb_7", 1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 2, !SUB,
            SUB ? 32'hFFFFFF88 : 32'h0, 8'h00, 32'h0);
        run("lbu_7", 1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 2, !SUB,
            SUB ? 32'h00000088 : 32'h0, 8'h00, 32'h0);
        run("sh_6", 1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234, SUB ? 3 : 2, !SUB,
            32'h0, SUB ? 8'h04 : 8'h00, SUB ? 32'h1234AABB : 32'h0);
        run("lw_4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2, 1'b0,
            SUB ? 32'h1234AABB : 32'h8899AABB, 8'h00, 32'h0);
        run("lh_4", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 2, !SUB,
            SUB ? 32'hFFFFAABB : 32'h0, 8'h00, 32'h0);
        run("lhu_6", 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 2, !SUB,
            SUB ? 32'h00001234 : 32'h0, 8'h00, 32'h0);
        run("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0,
            32'h0, 8'h02, 32'hDEADBEEF);
        chk("mem_10", mem[4], 32'hDEADBEEF);
        run("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0,
            32'hDEADBEEF, 8'h00, 32'h0);
        run("lh_5_err", 1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 2, 1'b1,
            32'h0, 8'h00, 32'h0);
        run("sw_6_err", 1'b1, 2'b10, 1'b0, 32'h6, 32'hCAFEF00D, 2, 1'b1,
            32'h0, 8'h00, 32'h0);
        chk("mem_4_after_err", mem[1], SUB ? 32'h1234AABB : 32'h8899AABB);
        run("size3_err", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 2, 1'b1,
            32'h0, 8'h00, 32'h0);
        run("sw_4_restore", 1'b1, 2'b10, 1'b0, 32'h4, 32'h8899AABB, 2, 1'b0,
            32'h0, 8'h02, 32'h8899AABB);

        // Abort a store in its write cycle with reset.
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SUB ? 2'b00 : 2'b10;
        req_addr  = 32'h4;
        req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (RST_CYC) @(negedge clk);
        chk("abort_we_before", {31'b0, mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_we_drop", {31'b0, mem_we}, 32'd0);
        chk("abort_wd_drop", mem_wd, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        nresp = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid)
                nresp++;
        end
        chk("abort_no_resp", nresp, 32'd0);
        chk("abort_mem_4", mem[1], 32'h8899AABB);
        chk("abort_ready_after", {31'b0, req_ready}, 32'd1);

        run("lb_4", 1'b0, 2'b00, 1'b0, 32'h4, 32'h0, 2, !SUB,
            SUB ? 32'hFFFFFFBB : 32'h0, 8'h00, 32'h0);
        run("lw_4_final", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2, 1'b0,
            32'h8899AABB, 8'h00, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
